// File: rtl/serial_subtractor_pkg.sv
// serial_sub_pkg: FSM state type and default operand width for serial_subtractor
package serial_sub_pkg;
  localparam int SUB_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit combinational x - y - bi cell, subtract twin of the full adder
module full_subtractor (
  input  logic i_x,
  input  logic i_y,
  input  logic i_bi,
  output logic o_d,
  output logic o_bo
);
  assign o_d  = i_x ^ i_y ^ i_bi;
  assign o_bo = (~i_x & i_y) | (~(i_x ^ i_y) & i_bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b, LSB first, one cell plus registered borrow; SERIAL_SUB_OVF_EN adds o_ovf
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             o_ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sa, r_sb, r_diff;
  logic [WIDTH-2:0] r_work;
  logic [CW-1:0]    r_cnt;
  logic             r_bin, r_done, r_borrow;
  logic             w_d, w_bo, w_last, w_accept;
  assign w_accept = (r_state == IDLE) && i_start;
  assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
  full_subtractor u_cell (
    .i_x (r_sa[0]),
    .i_y (r_sb[0]),
    .i_bi(r_bin),
    .o_d (w_d),
    .o_bo(w_bo)
  );
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  // next state: accept in IDLE, leave SHIFT on the terminal count, DONE lasts one cycle
  always_comb
    w_state_nxt = (r_state == IDLE)  ? (i_start ? SHIFT : IDLE) :
                  (r_state == SHIFT) ? (w_last ? DONE : SHIFT) : IDLE;
  // FSM outputs
  always_comb
    o_ready = (r_state == IDLE);
  // operand shifters, borrow chain and partial-result register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_bin  <= 1'b0;
      r_cnt  <= '0;
      r_work <= '0;
    end else if (w_accept) begin
      r_sa   <= i_a;
      r_sb   <= i_b;
      r_bin  <= 1'b0;
      r_cnt  <= '0;
      r_work <= '0;
    end else if (r_state == SHIFT) begin
      r_sa   <= r_sa >> 1;
      r_sb   <= r_sb >> 1;
      r_bin  <= w_bo;
      r_cnt  <= r_cnt + 1'b1;
      r_work <= (WIDTH-1)'({w_d, r_work} >> 1);
    end
  // result registers, loaded on the last shift step and held until the next one
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_diff   <= {w_d, r_work};
        r_borrow <= w_bo;
      end
    end
  assign o_done   = r_done;
  assign o_diff   = r_diff;
  assign o_borrow = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;
  // signed overflow: operand signs differ and the result sign differs from the minuend
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)    r_ovf <= 1'b0;
    else if (w_last) r_ovf <= (r_sa[0] ^ r_sb[0]) & (r_sa[0] ^ w_d);
  assign o_ovf = r_ovf;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       ready, done, borrow;
  logic [7:0] diff;
  int         n_pass = 0, n_total = 0;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  serial_subtractor #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
    .o_ready(ready), .o_done(done), .o_diff(diff), .o_borrow(borrow)
`ifdef SERIAL_SUB_OVF_EN
    , .o_ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, output int lat);
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    @(negedge clk);
    a = op_a; b = op_b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    #1;
    n_total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (diff !== 8'h00) $display("FAIL reset_diff got %h want 00", diff); else n_pass++;
    n_total++; if (borrow !== 1'b0) $display("FAIL reset_borrow got %b want 0", borrow); else n_pass++;
`ifdef SERIAL_SUB_OVF_EN
    n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else n_pass++;
`endif
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (ready !== 1'b1) $display("FAIL idle_ready got %b want 1", ready); else n_pass++;
  endtask

  task automatic test_directed;
    logic [7:0] va[6] = '{8'h05, 8'h03, 8'h80, 8'h00, 8'h7F, 8'hC8};
    logic [7:0] vb[6] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'hFF, 8'h64};
    logic [7:0] vd[6] = '{8'h02, 8'hFE, 8'h7F, 8'hFF, 8'h80, 8'h64};
    logic       vbo[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       vov[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], lat);
      n_total++; if (lat !== 9) $display("FAIL dir%0d_latency got %0d want 9", i, lat); else n_pass++;
      n_total++; if (diff !== vd[i]) $display("FAIL dir%0d_diff got %h want %h", i, diff, vd[i]); else n_pass++;
      n_total++; if (borrow !== vbo[i]) $display("FAIL dir%0d_borrow got %b want %b", i, borrow, vbo[i]); else n_pass++;
      n_total++; if (ready !== 1'b0) $display("FAIL dir%0d_ready_in_done got %b want 0", i, ready); else n_pass++;
`ifdef SERIAL_SUB_OVF_EN
      n_total++; if (ovf !== vov[i]) $display("FAIL dir%0d_ovf got %b want %b", i, ovf, vov[i]); else n_pass++;
`else
      if (vov[i] === 1'bx) $display("note: bad vector %0d", i);
`endif
      @(negedge clk);
      n_total++; if (done !== 1'b0) $display("FAIL dir%0d_done_pulse got %b want 0", i, done); else n_pass++;
      n_total++; if (ready !== 1'b1) $display("FAIL dir%0d_ready_back got %b want 1", i, ready); else n_pass++;
      n_total++; if (diff !== vd[i]) $display("FAIL dir%0d_diff_held got %h want %h", i, diff, vd[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int n_done = 0;
    logic acc;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e < 20; e++) begin
      if (e % 10 == 0) begin a = 8'hFF; b = 8'hFF; end
      else begin a = 8'($urandom); b = 8'($urandom); end
      acc = ready;
      n_total++; if (acc !== (e % 10 == 0)) $display("FAIL b2b_accept_edge%0d got %b want %b", e, acc, e % 10 == 0); else n_pass++;
      if (done) begin
        n_done++;
        n_total++; if (diff !== 8'h00) $display("FAIL b2b_diff got %h want 00", diff); else n_pass++;
        n_total++; if (borrow !== 1'b0) $display("FAIL b2b_borrow got %b want 0", borrow); else n_pass++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_total++; if (n_done !== 2) $display("FAIL b2b_done_count got %0d want 2", n_done); else n_pass++;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_abort;
    int lat, n_done = 0;
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (ready !== 1'b1) $display("FAIL abort_ready got %b want 1", ready); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else n_pass++;
    n_total++; if (diff !== 8'h00) $display("FAIL abort_diff got %h want 00", diff); else n_pass++;
    n_total++; if (borrow !== 1'b0) $display("FAIL abort_borrow got %b want 0", borrow); else n_pass++;
`ifdef SERIAL_SUB_OVF_EN
    n_total++; if (ovf !== 1'b0) $display("FAIL abort_ovf got %b want 0", ovf); else n_pass++;
`endif
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done) n_done++;
    end
    n_total++; if (n_done !== 0) $display("FAIL abort_no_done got %0d want 0", n_done); else n_pass++;
    run_op(8'h10, 8'h01, lat);
    n_total++; if (lat !== 9) $display("FAIL post_abort_latency got %0d want 9", lat); else n_pass++;
    n_total++; if (diff !== 8'h0F) $display("FAIL post_abort_diff got %h want 0F", diff); else n_pass++;
    n_total++; if (borrow !== 1'b0) $display("FAIL post_abort_borrow got %b want 0", borrow); else n_pass++;
  endtask

  task automatic test_random;
    logic [7:0] ra, rb, ed;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ed = ra - rb;
      run_op(ra, rb, lat);
      n_total++; if (lat !== 9) $display("FAIL rnd_latency %h-%h got %0d want 9", ra, rb, lat); else n_pass++;
      n_total++; if (diff !== ed) $display("FAIL rnd_diff %h-%h got %h want %h", ra, rb, diff, ed); else n_pass++;
      n_total++; if (borrow !== (ra < rb)) $display("FAIL rnd_borrow %h-%h got %b want %b", ra, rb, borrow, ra < rb); else n_pass++;
`ifdef SERIAL_SUB_OVF_EN
      n_total++; if (ovf !== ((ra[7] ^ rb[7]) & (ra[7] ^ ed[7])))
        $display("FAIL rnd_ovf %h-%h got %b want %b", ra, rb, ovf, (ra[7] ^ rb[7]) & (ra[7] ^ ed[7])); else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_abort;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
